// File: rtl/systolic_mm_stream.sv
// systolic_mm_stream
//   Output-stationary M x K systolic matrix-multiply core: Y = X(M x len) * W(len x K).
//   One reduction step (X column + W row) is accepted per beat on a valid/ready
//   handshake. X lanes are skewed by row and W lanes by column so that the operands
//   of one beat meet at every PE. A valid bit travels with the X data, so bubble
//   cycles never accumulate.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, len          begin a job of len reduction steps (sampled in IDLE only)
//   in_valid, in_ready  operand beat handshake
//   X, W                X column (M lanes), W row (K lanes), signed DATA_WIDTH each
//   busy                high whenever the engine is not idle
//   out_valid, out_ready result handshake
//   Y                   M*K signed ACC_WIDTH results, element (i,j) at ACC_WIDTH*(i*K+j)
//   sat_flag            (SYSTOLIC_MM_SAT_EN only) a PE saturated during this job
//
// Build option
//   SYSTOLIC_MM_SAT_EN  saturating accumulation plus the sat_flag output;
//                       without it accumulation wraps modulo 2^ACC_WIDTH.
//   ACC_WIDTH must be at least 2*DATA_WIDTH.
module systolic_mm_stream #(
  parameter int M          = 4,
  parameter int K          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LEN_WIDTH-1:0]      len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH*M-1:0]   X,
  input  logic [DATA_WIDTH*K-1:0]   W,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH*M*K-1:0]  Y
`ifdef SYSTOLIC_MM_SAT_EN
  ,
  output logic                      sat_flag
`endif
);

  localparam int DRAIN_W = (M + K > 2) ? $clog2(M + K) : 1;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t                  state_reg;
  logic [LEN_WIDTH-1:0]    len_reg;
  logic [LEN_WIDTH-1:0]    beat_cnt_reg;
  logic [DRAIN_W-1:0]      drain_cnt_reg;
  logic                    in_ready_reg;
  logic                    out_valid_reg;
  logic                    busy_reg;
  logic [ACC_WIDTH*M*K-1:0] y_reg;

  logic fire;
  logic acc_clr;

  // Array edge inputs after skewing, and the PE pipeline registers seen by neighbours.
  logic signed [DATA_WIDTH-1:0] x_edge [M];
  logic                         xv_edge [M];
  logic signed [DATA_WIDTH-1:0] w_edge [K];
  logic signed [DATA_WIDTH-1:0] x_pe [M][K];
  logic signed [DATA_WIDTH-1:0] w_pe [M][K];
  logic                         v_pe [M][K];
  logic [ACC_WIDTH*M*K-1:0]     acc_flat;

  assign fire    = in_valid && in_ready_reg;
  assign acc_clr = (state_reg == IDLE) && start;

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign Y         = y_reg;

  // X lane i: i register stages before the row's first PE; bubbles enter as valid=0.
  genvar gi, gj;
  generate
    for (gi = 0; gi < M; gi++) begin : g_xskew
      logic signed [DATA_WIDTH-1:0] x_lane;
      assign x_lane = fire ? X[DATA_WIDTH*gi +: DATA_WIDTH] : '0;
      if (gi == 0) begin : g_direct
        assign x_edge[gi]  = x_lane;
        assign xv_edge[gi] = fire;
      end else begin : g_delay
        logic signed [DATA_WIDTH-1:0] sr_reg  [gi];
        logic                         srv_reg [gi];
        always_ff @(posedge clk) begin
          if (rst) begin
            for (int s = 0; s < gi; s++) begin
              sr_reg[s]  <= '0;
              srv_reg[s] <= 1'b0;
            end
          end else begin
            sr_reg[0]  <= x_lane;
            srv_reg[0] <= fire;
            for (int s = 1; s < gi; s++) begin
              sr_reg[s]  <= sr_reg[s-1];
              srv_reg[s] <= srv_reg[s-1];
            end
          end
        end
        assign x_edge[gi]  = sr_reg[gi-1];
        assign xv_edge[gi] = srv_reg[gi-1];
      end
    end

    // W lane j: j register stages before the column's first PE.
    for (gj = 0; gj < K; gj++) begin : g_wskew
      logic signed [DATA_WIDTH-1:0] w_lane;
      assign w_lane = fire ? W[DATA_WIDTH*gj +: DATA_WIDTH] : '0;
      if (gj == 0) begin : g_direct
        assign w_edge[gj] = w_lane;
      end else begin : g_delay
        logic signed [DATA_WIDTH-1:0] sr_reg [gj];
        always_ff @(posedge clk) begin
          if (rst) begin
            for (int s = 0; s < gj; s++) sr_reg[s] <= '0;
          end else begin
            sr_reg[0] <= w_lane;
            for (int s = 1; s < gj; s++) sr_reg[s] <= sr_reg[s-1];
          end
        end
        assign w_edge[gj] = sr_reg[gj-1];
      end
    end
  endgenerate

`ifdef SYSTOLIC_MM_SAT_EN
  logic [M*K-1:0] sat_hit;
  logic           sat_flag_reg;
  assign sat_flag = sat_flag_reg;
`endif

  // PE grid: each PE registers its incoming operands (forwarding X right, W down)
  // and accumulates the registered pair on the following edge.
  generate
    for (gi = 0; gi < M; gi++) begin : g_row
      for (gj = 0; gj < K; gj++) begin : g_col
        logic signed [DATA_WIDTH-1:0]   x_in, w_in;
        logic                           v_in;
        logic signed [DATA_WIDTH-1:0]   x_reg, w_reg;
        logic                           v_reg;
        logic signed [ACC_WIDTH-1:0]    acc_reg;
        logic signed [2*DATA_WIDTH-1:0] prod;
        logic signed [ACC_WIDTH-1:0]    prod_ext, sum, acc_next;

        if (gj == 0) begin : g_xl
          assign x_in = x_edge[gi];
          assign v_in = xv_edge[gi];
        end else begin : g_xn
          assign x_in = x_pe[gi][gj-1];
          assign v_in = v_pe[gi][gj-1];
        end
        if (gi == 0) begin : g_wt
          assign w_in = w_edge[gj];
        end else begin : g_wn
          assign w_in = w_pe[gi-1][gj];
        end

        assign prod     = x_reg * w_reg;
        assign prod_ext = ACC_WIDTH'(prod);
        assign sum      = acc_reg + prod_ext;

`ifdef SYSTOLIC_MM_SAT_EN
        // Overflow only when both addends share a sign and the sum's sign differs.
        logic ovf;
        assign ovf = (acc_reg[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                     (sum[ACC_WIDTH-1] != acc_reg[ACC_WIDTH-1]);
        assign acc_next = !ovf ? sum :
                          acc_reg[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                               : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        assign sat_hit[gi*K+gj] = v_reg && ovf;
`else
        assign acc_next = sum;
`endif

        always_ff @(posedge clk) begin
          if (rst) begin
            x_reg   <= '0;
            w_reg   <= '0;
            v_reg   <= 1'b0;
            acc_reg <= '0;
          end else begin
            x_reg <= x_in;
            w_reg <= w_in;
            v_reg <= v_in;
            if (acc_clr)    acc_reg <= '0;
            else if (v_reg) acc_reg <= acc_next;
          end
        end

        assign x_pe[gi][gj] = x_reg;
        assign w_pe[gi][gj] = w_reg;
        assign v_pe[gi][gj] = v_reg;
        assign acc_flat[ACC_WIDTH*(gi*K+gj) +: ACC_WIDTH] = acc_reg;
      end
    end
  endgenerate

`ifdef SYSTOLIC_MM_SAT_EN
  always_ff @(posedge clk) begin
    if (rst || acc_clr) sat_flag_reg <= 1'b0;
    else if (|sat_hit)  sat_flag_reg <= 1'b1;
  end
`endif

  // Control FSM. drain_cnt_reg counts completed DRAIN cycles; the last beat
  // (edge cL) reaches PE(M-1,K-1) by edge cL+M+K-1, so Y is loaded at cL+M+K.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      beat_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      y_reg         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            beat_cnt_reg <= '0;
            busy_reg     <= 1'b1;
            if (len != '0) begin
              len_reg      <= len;
              in_ready_reg <= 1'b1;
              state_reg    <= FEED;
            end else begin
              y_reg         <= '0;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end
          end
        end
        FEED: begin
          if (fire) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
            if (beat_cnt_reg == len_reg - LEN_WIDTH'(1)) begin
              in_ready_reg  <= 1'b0;
              drain_cnt_reg <= '0;
              state_reg     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_reg == DRAIN_W'(M + K - 1)) begin
            y_reg         <= acc_flat;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
